// File: rtl/apb_pkg.sv
// Shared APB types: bus request/response bundles plus the
// master-bridge command, response and state encodings.
package apb_pkg;

   localparam int APB_ADDR_WIDTH      = 14;
   localparam int APB_DATA_WIDTH      = 32;
   localparam int APB_TIMEOUT_DEFAULT = 16;

   typedef enum logic {
      APB_READ  = 1'b0,
      APB_WRITE = 1'b1
   } apb_dir_e;

   typedef struct packed {
      logic [APB_ADDR_WIDTH-1:0] paddr;
      logic                      psel;
      logic                      penable;
      apb_dir_e                  pwrite;
      logic [APB_DATA_WIDTH-1:0] pwdata;
      logic                      pstrb;
   } apb_req_s;

   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] prdata;
      logic                      pready;
      logic                      pslverr;
   } apb_resp_s;

   typedef enum logic [1:0] {
      BR_IDLE,
      BR_SETUP,
      BR_ACCESS
   } apb_bridge_state_e;

   typedef struct packed {
      apb_dir_e                  write;
      logic [APB_ADDR_WIDTH-1:0] addr;
      logic [APB_DATA_WIDTH-1:0] wdata;
      logic                      strb;
   } apb_cmd_s;

   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] rdata;
      logic                      err;
      logic                      timeout;
   } apb_rsp_s;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB SETUP/ACCESS transfers, with a
// one-entry response slot and an optional wait-state timeout.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   input  logic                  cmd_strb_i,
   output apb_req_s              apb_req_o,
   input  apb_resp_s             apb_resp_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   apb_bridge_state_e state, state_d;
   logic [CW-1:0]     cnt;
   apb_req_s          req;
   apb_rsp_s          rsp;
   apb_cmd_s          cmd;
   logic              rsp_valid;
   logic              accept, done, abort;

   assign cmd.write = apb_dir_e'(cmd_write_i);
   assign cmd.addr  = cmd_addr_i;
   assign cmd.wdata = cmd_wdata_i;
   assign cmd.strb  = cmd_write_i & cmd_strb_i;

   assign cmd_ready_o   = (state == BR_IDLE) && (!rsp_valid || rsp_ready_i);
   assign apb_req_o     = req;
   assign rsp_valid_o   = rsp_valid;
   assign rsp_rdata_o   = rsp.rdata;
   assign rsp_err_o     = rsp.err;
   assign rsp_timeout_o = rsp.timeout;

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state)
         BR_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               accept  = 1'b1;
               state_d = BR_SETUP;
            end
         end
         BR_SETUP: state_d = BR_ACCESS;
         BR_ACCESS: begin
            if (apb_resp_i.pready) begin
               done    = 1'b1;
               state_d = BR_IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
               abort   = 1'b1;
               state_d = BR_IDLE;
            end
         end
         default: state_d = BR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BR_IDLE;
         cnt       <= '0;
         req       <= '0;
         rsp       <= '0;
         rsp_valid <= 1'b0;
      end else begin
         state <= state_d;
         if (accept) begin
            req.paddr   <= cmd.addr;
            req.pwrite  <= cmd.write;
            req.pwdata  <= cmd.wdata;
            req.pstrb   <= cmd.strb;
            req.psel    <= 1'b1;
            req.penable <= 1'b0;
         end
         if (state == BR_SETUP) begin
            req.penable <= 1'b1;
            cnt         <= '0;
         end
         if ((state == BR_ACCESS) && !done && !abort)
            cnt <= cnt + CW'(1);
         if (done || abort) begin
            req.psel    <= 1'b0;
            req.penable <= 1'b0;
         end
         // a completion can never coincide with a consume: IDLE->SETUP->ACCESS
         if (done) begin
            rsp_valid   <= 1'b1;
            rsp.err     <= apb_resp_i.pslverr;
            rsp.timeout <= 1'b0;
            rsp.rdata   <= (req.pwrite == APB_WRITE) ? '0 : apb_resp_i.prdata;
         end else if (abort) begin
            rsp_valid   <= 1'b1;
            rsp.err     <= 1'b1;
            rsp.timeout <= 1'b1;
            rsp.rdata   <= '0;
         end else if (rsp_valid && rsp_ready_i) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed test-plan cases with literal
// expectations, then random traffic against a transaction-age model.
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_strb_i;
   logic [13:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   apb_req_s    apb_req_o;
   apb_resp_s   apb_resp_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
   logic [31:0] rsp_rdata_o;

   int checks = 0;
   int failures = 0;

   apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
      .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
      .apb_req_o(apb_req_o), .apb_resp_i(apb_resp_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: age = cycles since acceptance (0 idle, 1 setup, >=2 access).
   int          m_age, n_age;
   logic        m_wr, n_wr, m_strb, n_strb;
   logic [13:0] m_addr, n_addr;
   logic [31:0] m_wd, n_wd, m_rd, n_rd;
   logic        m_rv, n_rv, m_err, n_err, m_to, n_to;
   logic        synced = 1'b0, n_sync;

   always @(negedge clk) begin
      logic exp_ready;
      exp_ready = (m_age == 0) && (!m_rv || rsp_ready_i);
      if (synced) begin
         chk("cmd_ready", cmd_ready_o, exp_ready);
         chk("psel", apb_req_o.psel, m_age > 0);
         chk("penable", apb_req_o.penable, m_age >= 2);
         if (m_age > 0) begin
            chk("paddr", apb_req_o.paddr, m_addr);
            chk("pwrite", apb_req_o.pwrite, m_wr);
            chk("pstrb", apb_req_o.pstrb, m_strb);
            if (m_wr) chk("pwdata", apb_req_o.pwdata, m_wd);
         end
         chk("rsp_valid", rsp_valid_o, m_rv);
         chk("rsp_rdata", rsp_rdata_o, m_rd);
         chk("rsp_err", rsp_err_o, m_err);
         chk("rsp_timeout", rsp_timeout_o, m_to);
      end
      n_age = m_age; n_wr = m_wr; n_strb = m_strb; n_addr = m_addr;
      n_wd = m_wd; n_rv = m_rv; n_rd = m_rd; n_err = m_err; n_to = m_to;
      n_sync = synced;
      if (rst === 1'b1) begin
         n_age = 0; n_wr = 0; n_strb = 0; n_addr = '0; n_wd = '0;
         n_rv = 0; n_rd = '0; n_err = 0; n_to = 0; n_sync = 1'b1;
      end else if (synced) begin
         if (m_rv && rsp_ready_i) n_rv = 1'b0;
         if (m_age == 0) begin
            if (cmd_valid_i && exp_ready) begin
               n_age = 1; n_wr = cmd_write_i; n_addr = cmd_addr_i;
               n_wd = cmd_wdata_i; n_strb = cmd_write_i & cmd_strb_i;
            end
         end else if (m_age == 1) begin
            n_age = 2;
         end else if (apb_resp_i.pready) begin
            n_age = 0; n_rv = 1; n_err = apb_resp_i.pslverr; n_to = 0;
            n_rd = m_wr ? 32'h0 : apb_resp_i.prdata;
         end else if (m_age - 1 == TO) begin
            n_age = 0; n_rv = 1; n_err = 1; n_to = 1; n_rd = '0;
         end else begin
            n_age = m_age + 1;
         end
      end
   end

   always @(posedge clk) begin
      m_age = n_age; m_wr = n_wr; m_strb = n_strb; m_addr = n_addr;
      m_wd = n_wd; m_rv = n_rv; m_rd = n_rd; m_err = n_err; m_to = n_to;
      synced = n_sync;
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic cmd(logic w, logic [13:0] a, logic [31:0] d, logic s);
      cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a;
      cmd_wdata_i = d; cmd_strb_i = s;
   endtask

   initial begin
      logic acc;
      int   mode;
      rst = 1'b1; cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0;
      cmd_wdata_i = '0; cmd_strb_i = 0; apb_resp_i = '0; rsp_ready_i = 1;
      m_age = 0; m_wr = 0; m_strb = 0; m_addr = '0; m_wd = '0;
      m_rv = 0; m_rd = '0; m_err = 0; m_to = 0;
      nxt(); nxt();
      mid();
      chk("rst_req", apb_req_o, '0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      nxt(); rst = 1'b0;

      // zero-wait write
      cmd(1, 14'h0123, 32'hDEADBEEF, 1);
      apb_resp_i = '{prdata: 32'h0, pready: 1'b1, pslverr: 1'b0};
      mid(); chk("wr_accept", cmd_ready_o, 1);
      nxt(); cmd_valid_i = 0;
      mid(); chk("wr_t1_psel", apb_req_o.psel, 1);
      chk("wr_t1_pen", apb_req_o.penable, 0);
      chk("wr_t1_addr", apb_req_o.paddr, 14'h0123);
      nxt(); mid(); chk("wr_t2_pen", apb_req_o.penable, 1);
      nxt(); mid(); chk("wr_t3_rv", rsp_valid_o, 1);
      chk("wr_t3_err", rsp_err_o, 0); chk("wr_t3_rd", rsp_rdata_o, 0);

      // read, two wait states
      nxt(); cmd(0, 14'h3FFF, 32'h0, 0);
      apb_resp_i = '{prdata: 32'hA5A55A5A, pready: 1'b0, pslverr: 1'b0};
      nxt(); cmd_valid_i = 0;
      nxt(); nxt(); nxt(); apb_resp_i.pready = 1'b1;
      mid(); chk("rd_addr_stable", apb_req_o.paddr, 14'h3FFF);
      chk("rd_t4_rv", rsp_valid_o, 0);
      nxt(); mid(); chk("rd_t5_rv", rsp_valid_o, 1);
      chk("rd_t5_rd", rsp_rdata_o, 32'hA5A55A5A);

      // slave error
      nxt(); cmd(0, 14'h0010, 32'h0, 0);
      apb_resp_i = '{prdata: 32'h1234, pready: 1'b1, pslverr: 1'b1};
      nxt(); cmd_valid_i = 0;
      nxt(); nxt(); mid();
      chk("err_err", rsp_err_o, 1); chk("err_to", rsp_timeout_o, 0);
      chk("err_rd", rsp_rdata_o, 32'h1234);

      // timeout, response held so the late PREADY can be observed
      nxt(); cmd(0, 14'h0020, 32'h0, 0); rsp_ready_i = 1;
      apb_resp_i = '{prdata: 32'h77, pready: 1'b0, pslverr: 1'b0};
      nxt(); cmd_valid_i = 0; rsp_ready_i = 0;
      nxt(); nxt(); nxt(); nxt(); mid();
      chk("to_t5_pen", apb_req_o.penable, 1);
      nxt(); mid(); chk("to_t6_psel", apb_req_o.psel, 0);
      chk("to_err", rsp_err_o, 1); chk("to_to", rsp_timeout_o, 1);
      chk("to_rd", rsp_rdata_o, 0);
      apb_resp_i.pready = 1'b1;
      nxt(); apb_resp_i.pready = 1'b0;
      mid(); chk("to_late_to", rsp_timeout_o, 1);
      chk("to_late_psel", apb_req_o.psel, 0);
      nxt(); rsp_ready_i = 1;

      // back-pressure with two queued writes
      nxt(); cmd(1, 14'h0100, 32'h11111111, 1); rsp_ready_i = 0;
      apb_resp_i = '{prdata: 32'h0, pready: 1'b1, pslverr: 1'b0};
      nxt(); cmd(1, 14'h0200, 32'h22222222, 1);
      nxt(); nxt();
      for (int i = 0; i < 5; i++) begin
         mid(); chk("bp_ready", cmd_ready_o, 0);
         chk("bp_rv", rsp_valid_o, 1);
         nxt();
      end
      rsp_ready_i = 1;
      mid(); chk("bp_accept", cmd_ready_o, 1);
      nxt(); cmd_valid_i = 0;
      mid(); chk("bp_b_addr", apb_req_o.paddr, 14'h0200);
      chk("bp_rv_clear", rsp_valid_o, 0);
      nxt(); nxt(); nxt();

      // reset during a waiting ACCESS
      cmd(0, 14'h0040, 32'h0, 0); apb_resp_i.pready = 1'b0;
      nxt(); cmd_valid_i = 0;
      nxt(); nxt(); rst = 1;
      nxt(); rst = 0;
      mid(); chk("rstm_req", apb_req_o, '0);
      chk("rstm_rv", rsp_valid_o, 0);
      nxt(); nxt(); mid(); chk("rstm_rv2", rsp_valid_o, 0);
      cmd(1, 14'h0050, 32'hCAFEF00D, 1); apb_resp_i.pready = 1'b1;
      nxt(); cmd_valid_i = 0;
      nxt(); nxt(); mid(); chk("rstm_fresh_rv", rsp_valid_o, 1);

      // random traffic
      acc = 1'b1; mode = 0;
      for (int c = 0; c < 3000; c++) begin
         nxt();
         if (c % 250 == 0) mode = $urandom_range(0, 2);
         rst = ($urandom_range(0, 299) == 0);
         if (!cmd_valid_i || acc) begin
            cmd_valid_i = $urandom_range(0, 1);
            cmd_write_i = $urandom_range(0, 1);
            cmd_addr_i  = 14'($urandom);
            cmd_wdata_i = $urandom;
            cmd_strb_i  = $urandom_range(0, 1);
         end
         apb_resp_i.prdata  = $urandom;
         apb_resp_i.pslverr = ($urandom_range(0, 3) == 0);
         case (mode)
            0: apb_resp_i.pready = ($urandom_range(0, 1) == 0);
            1: apb_resp_i.pready = ($urandom_range(0, 9) == 0);
            default: apb_resp_i.pready = ($urandom_range(0, 9) != 0);
         endcase
         rsp_ready_i = ($urandom_range(0, 4) < 3);
         mid();
         acc = cmd_valid_i && cmd_ready_o && !rst;
      end

      nxt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
